// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and field positions for the pipeline controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

  // Bit positions inside the EX/MEM M-field
  localparam int BR_BIT  = 2;
  localparam int MRD_BIT = 1;
  localparam int MWR_BIT = 0;

  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between ID and EX
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rn,
  input  logic [4:0] rm,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  // XZR reads always return zero, so a load targeting it never creates a dependency
  always_comb begin
    load_use = ex_mem_read && (ex_rd != XZR_IDX) && ((ex_rd == rn) || (ex_rd == rm));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline enable/flush controller with memory freeze and watchdog
// Optional stall/flush counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [4:0] IfIdRn,
  input  logic [4:0] IfIdRm,
  input  logic       IdExMemRead,
  input  logic [4:0] IdExRd,
  input  logic [2:0] ExMemM,
  input  logic       ExMemZero,
  input  logic       MemAck,
  output logic       PcWrite,
  output logic       IfIdWrite,
  output logic       IdExWrite,
  output logic       ExMemWrite,
  output logic       MemWbWrite,
  output logic       IdExBubble,
  output logic       IfIdFlush,
  output logic       IdExFlush,
  output logic       ExMemFlush,
  output logic       PcSrc,
  output logic       MemReq,
  output logic       MemErr
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  // Watchdog value on the last MEM_WAIT cycle before the trap
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  ctrl_state_t state;
  logic [7:0]  wdog;
  logic        load_use;
  logic        mem_op;
  logic        br_taken;
  logic        en_all;

  hazard_detect u_hazard_detect (
    .rn          (IfIdRn),
    .rm          (IfIdRm),
    .ex_mem_read (IdExMemRead),
    .ex_rd       (IdExRd),
    .load_use    (load_use)
  );

  assign mem_op   = ExMemM[MRD_BIT] | ExMemM[MWR_BIT];
  assign br_taken = ExMemM[BR_BIT] & ExMemZero;

  always_comb begin
    en_all     = 1'b0;
    PcWrite    = 1'b0;
    IfIdWrite  = 1'b0;
    IdExWrite  = 1'b0;
    ExMemWrite = 1'b0;
    MemWbWrite = 1'b0;
    IdExBubble = 1'b0;
    IfIdFlush  = 1'b0;
    IdExFlush  = 1'b0;
    ExMemFlush = 1'b0;
    PcSrc      = 1'b0;
    MemReq     = 1'b0;
    MemErr     = 1'b0;
    if (!Rst_n) begin
      IfIdFlush  = 1'b1;
      IdExFlush  = 1'b1;
      ExMemFlush = 1'b1;
    end else begin
      case (state)
        ERROR: MemErr = 1'b1;
        MEM_WAIT: begin
          MemReq = 1'b1;
          en_all = MemAck;
        end
        RUN: begin
          if (mem_op) begin
            MemReq = 1'b1;
            en_all = MemAck;
          end else if (br_taken) begin
            en_all     = 1'b1;
            PcSrc      = 1'b1;
            IfIdFlush  = 1'b1;
            IdExFlush  = 1'b1;
            ExMemFlush = 1'b1;
          end else if (load_use) begin
            IdExWrite  = 1'b1;
            ExMemWrite = 1'b1;
            MemWbWrite = 1'b1;
            IdExBubble = 1'b1;
          end else begin
            en_all = 1'b1;
          end
        end
        default: MemErr = 1'b1;
      endcase
      if (en_all) begin
        PcWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        IdExWrite  = 1'b1;
        ExMemWrite = 1'b1;
        MemWbWrite = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= RUN;
      wdog  <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (mem_op && !MemAck) begin
            state <= MEM_WAIT;
            wdog  <= 8'd0;
          end
        end
        MEM_WAIT: begin
          wdog <= wdog + 8'd1;
          if (MemAck) begin
            state <= RUN;
          end else if (wdog == WDOG_LAST) begin
            state <= ERROR;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (!PcWrite) StallCount <= StallCount + 32'd1;
      if (PcSrc)    FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table and scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  // Output packing: {PcWrite,IfIdWrite,IdExWrite,ExMemWrite,MemWbWrite,IdExBubble,
  //                  IfIdFlush,IdExFlush,ExMemFlush,PcSrc,MemReq,MemErr}
  localparam logic [11:0] E_IDLE = 12'b1111_1000_0000;
  localparam logic [11:0] E_RST  = 12'b0000_0011_1000;
  localparam logic [11:0] E_LU   = 12'b0011_1100_0000;
  localparam logic [11:0] E_BR   = 12'b1111_1011_1100;
  localparam logic [11:0] E_FRZ  = 12'b0000_0000_0010;
  localparam logic [11:0] E_ACK  = 12'b1111_1000_0010;
  localparam logic [11:0] E_ERR  = 12'b0000_0000_0001;

  typedef struct packed {
    logic        rst_n;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        mrd;
    logic [4:0]  rd;
    logic [2:0]  m;
    logic        zero;
    logic        ack;
    logic [11:0] exp;
  } vec_t;

  typedef struct packed {
    logic        sel;
    logic [11:0] exp;
    logic [15:0] id;
  } sb_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst_n;
  logic [4:0] IfIdRn, IfIdRm, IdExRd;
  logic       IdExMemRead;
  logic [2:0] ExMemM;
  logic       ExMemZero, MemAck;

  logic a_pcw, a_ifw, a_idw, a_exw, a_mww, a_bub, a_iff, a_idf, a_exf, a_src, a_req, a_err;
  logic b_pcw, b_ifw, b_idw, b_exw, b_mww, b_bub, b_iff, b_idf, b_exf, b_src, b_req, b_err;
  logic [11:0] a_out, b_out;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

  assign a_out = {a_pcw, a_ifw, a_idw, a_exw, a_mww, a_bub, a_iff, a_idf, a_exf, a_src, a_req, a_err};
  assign b_out = {b_pcw, b_ifw, b_idw, b_exw, b_mww, b_bub, b_iff, b_idf, b_exf, b_src, b_req, b_err};

  pipe_hazard_ctrl u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .IfIdRn(IfIdRn), .IfIdRm(IfIdRm),
    .IdExMemRead(IdExMemRead), .IdExRd(IdExRd), .ExMemM(ExMemM),
    .ExMemZero(ExMemZero), .MemAck(MemAck),
    .PcWrite(a_pcw), .IfIdWrite(a_ifw), .IdExWrite(a_idw), .ExMemWrite(a_exw),
    .MemWbWrite(a_mww), .IdExBubble(a_bub), .IfIdFlush(a_iff), .IdExFlush(a_idf),
    .ExMemFlush(a_exf), .PcSrc(a_src), .MemReq(a_req), .MemErr(a_err)
`ifdef PIPE_PERF_CNT_EN
    , .StallCount(a_stall), .FlushCount(a_flush)
`endif
  );

  pipe_hazard_ctrl #(.TIMEOUT(3)) u_dut_to (
    .Clk(Clk), .Rst_n(Rst_n), .IfIdRn(IfIdRn), .IfIdRm(IfIdRm),
    .IdExMemRead(IdExMemRead), .IdExRd(IdExRd), .ExMemM(ExMemM),
    .ExMemZero(ExMemZero), .MemAck(MemAck),
    .PcWrite(b_pcw), .IfIdWrite(b_ifw), .IdExWrite(b_idw), .ExMemWrite(b_exw),
    .MemWbWrite(b_mww), .IdExBubble(b_bub), .IfIdFlush(b_iff), .IdExFlush(b_idf),
    .ExMemFlush(b_exf), .PcSrc(b_src), .MemReq(b_req), .MemErr(b_err)
`ifdef PIPE_PERF_CNT_EN
    , .StallCount(b_stall), .FlushCount(b_flush)
`endif
  );

  vec_t vecs[22];
  sb_t  sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic rst_n, input logic [4:0] rn, input logic [4:0] rm,
                              input logic mrd, input logic [4:0] rd, input logic [2:0] m,
                              input logic zero, input logic ack, input logic [11:0] exp);
    vec_t v;
    v = '{rst_n, rn, rm, mrd, rd, m, zero, ack, exp};
    return v;
  endfunction

  task automatic set_in(input vec_t v);
    Rst_n       = v.rst_n;
    IfIdRn      = v.rn;
    IfIdRm      = v.rm;
    IdExMemRead = v.mrd;
    IdExRd      = v.rd;
    ExMemM      = v.m;
    ExMemZero   = v.zero;
    MemAck      = v.ack;
  endtask

  task automatic push(input logic sel, input logic [11:0] exp, input int id);
    sb.push_back('{sel, exp, 16'(id)});
  endtask

  task automatic tick();
    sb_t e;
    logic [11:0] act;
    @(negedge Clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.sel ? b_out : a_out;
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s id=%0d actual=%b required=%b", e.sel ? "to_dut" : "main_dut", e.id, act, e.exp);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, E_RST);
    vecs[1]  = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, E_IDLE);
    vecs[2]  = mk(1, 5, 0, 1, 5, 3'b000, 0, 0, E_LU);
    vecs[3]  = mk(1, 5, 0, 0, 5, 3'b000, 0, 0, E_IDLE);
    vecs[4]  = mk(1, 3, 7, 1, 7, 3'b000, 0, 0, E_LU);
    vecs[5]  = mk(1, 31, 31, 1, 31, 3'b000, 0, 0, E_IDLE);
    vecs[6]  = mk(1, 6, 4, 1, 5, 3'b000, 0, 0, E_IDLE);
    vecs[7]  = mk(1, 5, 0, 1, 5, 3'b100, 1, 0, E_BR);
    vecs[8]  = mk(1, 0, 0, 0, 0, 3'b100, 0, 0, E_IDLE);
    vecs[9]  = mk(1, 0, 0, 0, 0, 3'b000, 0, 1, E_IDLE);
    vecs[10] = mk(1, 0, 0, 0, 0, 3'b010, 0, 1, E_ACK);
    vecs[11] = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, E_IDLE);
    vecs[12] = mk(1, 0, 0, 0, 0, 3'b001, 0, 0, E_FRZ);
    vecs[13] = mk(1, 0, 0, 0, 0, 3'b001, 0, 0, E_FRZ);
    vecs[14] = mk(1, 0, 0, 0, 0, 3'b001, 0, 0, E_FRZ);
    vecs[15] = mk(1, 0, 0, 0, 0, 3'b001, 0, 0, E_FRZ);
    vecs[16] = mk(1, 0, 0, 0, 0, 3'b001, 0, 1, E_ACK);
    vecs[17] = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, E_IDLE);
    vecs[18] = mk(1, 0, 0, 0, 0, 3'b010, 0, 0, E_FRZ);
    vecs[19] = mk(1, 0, 0, 0, 0, 3'b010, 0, 0, E_FRZ);
    vecs[20] = mk(0, 0, 0, 0, 0, 3'b010, 0, 0, E_RST);
    vecs[21] = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, E_IDLE);

    for (int i = 0; i < 22; i++) begin
      set_in(vecs[i]);
      push(1'b0, vecs[i].exp, i);
      tick();
    end

    // Watchdog trap on the TIMEOUT=3 instance, then sticky until reset
    set_in(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, E_RST));
    push(1'b1, E_RST, 100);
    tick();
    for (int k = 1; k <= 8; k++) begin
      set_in(mk(1, 0, 0, 0, 0, 3'b010, 0, 0, E_FRZ));
      push(1'b1, (k <= 4) ? E_FRZ : E_ERR, 100 + k);
      if (k == 8) push(1'b0, E_FRZ, 120);
      tick();
    end
    set_in(mk(1, 0, 0, 0, 0, 3'b000, 0, 1, E_ERR));
    push(1'b1, E_ERR, 121);
    push(1'b0, E_ACK, 122);
    tick();
    set_in(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, E_ERR));
    push(1'b1, E_ERR, 123);
    push(1'b0, E_IDLE, 124);
    tick();
    set_in(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, E_RST));
    push(1'b1, E_RST, 125);
    tick();
    set_in(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, E_IDLE));
    push(1'b1, E_IDLE, 126);
    push(1'b0, E_IDLE, 127);
    tick();

`ifdef PIPE_PERF_CNT_EN
    set_in(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, E_RST));
    tick();
    set_in(mk(1, 5, 0, 1, 5, 3'b000, 0, 0, E_LU));
    tick();
    set_in(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, E_IDLE));
    tick();
    for (int k = 0; k < 4; k++) begin
      set_in(mk(1, 0, 0, 0, 0, 3'b010, 0, 0, E_FRZ));
      tick();
    end
    set_in(mk(1, 0, 0, 0, 0, 3'b010, 0, 1, E_ACK));
    tick();
    set_in(mk(1, 0, 0, 0, 0, 3'b100, 1, 0, E_BR));
    tick();
    set_in(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, E_IDLE));
    tick();
    checks++;
    if (a_stall !== 32'd5) begin
      failures++;
      $display("FAIL stall_count actual=%0d required=5", a_stall);
    end
    checks++;
    if (a_flush !== 32'd1) begin
      failures++;
      $display("FAIL flush_count actual=%0d required=1", a_flush);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 64-bit five-stage datapath. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, resolves taken branches from the EX/MEM stage, and freezes the pipeline around a multi-cycle data-memory handshake, with a watchdog timeout. It sits beside the pipeline registers and is the only source of their enables.

## Interface
- TIMEOUT, 255: maximum MEM_WAIT cycles before the error trap. Range 1..255; the counter is 8 bits.
- Clk  in  1  single clock, rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- IfIdRn, IfIdRm  in  5 each  source registers of the instruction in ID.
- IdExMemRead  in  1  instruction in EX is a load.
- IdExRd  in  5  destination register of the instruction in EX.
- ExMemM  in  3  EX/MEM M-field: [2] Branch, [1] MemRead, [0] MemWrite.
- ExMemZero  in  1  EX/MEM zero flag.
- MemAck  in  1  data memory completes the current access this cycle.
- PcWrite, IfIdWrite, IdExWrite, ExMemWrite, MemWbWrite  out  1 each  register enables.
- IdExBubble  out  1  load zeros into the ID/EX control fields.
- IfIdFlush, IdExFlush, ExMemFlush  out  1 each  squash the younger instructions.
- PcSrc  out  1  select the branch target.
- MemReq  out  1  data-memory request.
- MemErr  out  1  sticky timeout error.

## Operation
- States: RUN, MEM_WAIT, ERROR. Encoding is 2 bits, defined in the package.
- Priority within a cycle: ERROR, then memory freeze, then branch flush, then load-use stall.
- Memory op: `mem_op = ExMemM[1] | ExMemM[0]`.
- **RUN with mem_op:**
  - MemReq=1.
  - If MemAck=1 in the same cycle (zero-wait access), all enables are 1 and the state stays RUN.
  - Otherwise all enables are 0, the state goes to MEM_WAIT and the watchdog is cleared to 0.
- **MEM_WAIT:**
  - MemReq=1 and all enables are 0.
  - The watchdog increments every cycle.
  - On MemAck=1, all enables are 1 for that cycle and the next state is RUN.
  - If the watchdog reaches TIMEOUT without MemAck, the next state is ERROR.
- **ERROR:**
  - All enables are 0, MemReq=0 and MemErr=1.
  - Exit is only by reset.
- **Branch taken** (`ExMemM[2] & ExMemZero`) in RUN with no freeze:
  - PcSrc=1 and IfIdFlush=IdExFlush=ExMemFlush=1.
  - All enables are 1.
  - Any load-use stall in the same cycle is ignored, because the flush wins.
- **Load-use** (`IdExMemRead & IdExRd != 31 & (IdExRd == IfIdRn | IdExRd == IfIdRm)`) in RUN, with no freeze and no branch:
  - PcWrite=0, IfIdWrite=0, IdExBubble=1.
  - IdExWrite, ExMemWrite and MemWbWrite stay 1.
  - Exactly one bubble is inserted, because the load moves on to EX/MEM.
- Register X31 (XZR) never causes a hazard.
- Idle RUN: all enables are 1 and every other output is 0.

## Timing
- Outputs are combinational from the state register and the current inputs. There are no registered outputs.
- State, the watchdog and MemErr update on the rising edge of Clk.
- While Rst_n=0:
  - All enables are 0.
  - All flushes are 1, so the pipeline is cleared.
  - PcSrc, IdExBubble, MemReq and MemErr are 0.
  - The state returns to RUN and the watchdog is cleared.
- Reset asserted during MEM_WAIT abandons the access: MemReq falls in the same cycle.
- Memory freeze latency: an access with N wait cycles costs N stall cycles. With MemAck on the first cycle the cost is 0.
- Branch penalty is 3 flushed instructions, and PcSrc is asserted for exactly 1 cycle.
- MemAck while MemReq=0 is ignored.
- Timeout: with no MemAck, ERROR is entered on the edge after the watchdog equals TIMEOUT, i.e. TIMEOUT+1 cycles after the request.

## Configuration
- Macro: PIPE_PERF_CNT_EN.
- **With the macro defined:**
  - Two extra output ports, StallCount and FlushCount, each 32 bits.
  - StallCount increments each cycle with PcWrite=0 outside reset.
  - FlushCount increments on each taken branch.
  - Both counters clear on reset and wrap modulo 2^32.
- **Without the macro:** neither the ports nor the counter logic exist.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum;
  - the M-field bit positions (BR_BIT=2, MRD_BIT=1, MWR_BIT=0);
  - XZR_IDX=31.
- One natural sub-module, hazard_detect: the purely combinational load-use comparator.
- The FSM, watchdog and optional counters live in pipe_hazard_ctrl itself.

## Test plan
- **Load-use:** IdExMemRead=1, IdExRd=5, IfIdRn=5. Expect PcWrite=0, IfIdWrite=0 and IdExBubble=1 for one cycle, then all 0/1 idle values. Repeat with IdExRd=31 and expect no stall.
- **Branch:** ExMemM=3'b100, ExMemZero=1, with a simultaneous load-use. Expect PcSrc=1 and all three flushes=1 for one cycle, IdExBubble=0 and all enables=1.
- **Memory wait:** ExMemM=3'b010 with MemAck arriving 4 cycles later. Expect MemReq=1 for 5 cycles and enables=0 for 4 cycles, then enables=1 on the ack cycle and RUN after it. With MemAck=1 immediately, expect zero stall cycles.
- **Timeout:** TIMEOUT=3, MemReq held with no MemAck. Expect MemErr=1 from the 5th cycle onward, all enables=0 and MemReq=0. Expect it to clear only after Rst_n=0.
- **Reset mid-wait:** assert Rst_n=0 in the 2nd MEM_WAIT cycle. Expect MemReq=0 and all flushes=1 immediately, and RUN with enables=1 after release.
- **PIPE_PERF_CNT_EN:** the load-use case plus the 4-wait access gives StallCount=5, and one branch gives FlushCount=1.
